// File: rtl/stream_mux_rr_pkg.sv
// Shared encodings for the stream_mux_rr slice: selection mode values.
package stream_mux_rr_pkg;

    typedef enum logic {
        MODE_ADDR = 1'b0,
        MODE_RR   = 1'b1
    } mux_mode_e;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: first requester after ptr, modulo CHANNELS.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller gates the grant with its own load enable.
module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int SELW     = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic                grant_valid,
    output logic [SELW-1:0]     grant
);

    logic [2*CHANNELS-1:0] dbl;
    logic [CHANNELS-1:0]   rot;
    int                    first;
    int                    idx;

    always_comb begin
        // After the shift, rot[k] is the request of channel (ptr+1+k) mod CHANNELS.
        dbl = {req, req} >> (int'(ptr) + 1);
        rot = dbl[CHANNELS-1:0];

        grant_valid = 1'b0;
        first       = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant_valid = 1'b1;
                first       = k;
            end
        end

        idx = int'(ptr) + 1 + first;
        if (idx >= CHANNELS) begin
            idx = idx - CHANNELS;
        end
        grant = SELW'(idx);
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux, addressed or round-robin selection.
// Latency: one cycle, sustaining one transfer per cycle.
// Backpressure: a held word stalls all inputs until the consumer accepts it.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SELW     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SELW-1:0]           address,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SELW-1:0]           out_channel
);

    logic [SELW-1:0]  rr_ptr;
    logic             rr_valid;
    logic [SELW-1:0]  rr_grant;
    logic             addr_valid;
    logic             grant_valid;
    logic [SELW-1:0]  grant;
    logic             load_en;
    logic [WIDTH-1:0] grant_data;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_arb (
        .req         (in_valid),
        .ptr         (rr_ptr),
        .grant_valid (rr_valid),
        .grant       (rr_grant)
    );

    // Decoding the address against each real channel keeps out-of-range
    // addresses from ever granting or indexing past in_valid.
    always_comb begin
        addr_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (address == SELW'(i) && in_valid[i]) begin
                addr_valid = 1'b1;
            end
        end
    end

    always_comb begin
        grant_valid = (mode == MODE_RR) ? rr_valid : addr_valid;
        grant       = (mode == MODE_RR) ? rr_grant : address;
        load_en     = !out_valid || out_ready;

        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = !reset && load_en && grant_valid && (grant == SELW'(i));
            if (grant == SELW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_channel <= '0;
            rr_ptr      <= SELW'(CHANNELS - 1);
        end else if (load_en) begin
            if (grant_valid) begin
                out_valid   <= 1'b1;
                out_data    <= grant_data;
                out_channel <= grant;
                rr_ptr      <= grant;
            end else begin
                out_valid   <= 1'b0;
            end
        end
    end

endmodule
